lane_pack_8: RTL and testbench

LANE_PACK_8 -- requirements
Module: lane_pack_8

---
 rtl/lane_pack_8.sv | 105 ++++++++++
 tb/tb_lane_pack_8.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_pack_8.sv
`default_nettype none
// ============================================================================
//  Module   : lane_pack_8
//  Purpose  : Packs a serial stream of 32-bit words into groups of eight
//             parallel lanes and frames the groups into frames of
//             N = input_x*input_y groups (sof/eof marking, framing errors).
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//     clk            in   1   clock, rising edge
//     rst            in   1   asynchronous active-high reset
//     in_valid       in   1   in_data/in_sof qualified (always accepted)
//     in_sof         in   1   first word of a new frame
//     in_data        in  32   serial word
//     out_valid      out  1   one-cycle pulse, new group on data_out_0..7
//     out_sof        out  1   first group of frame (with out_valid)
//     out_eof        out  1   last group of frame (with out_valid)
//     data_out_0..7  out 32   lane k = k-th word of the group
//     err            out  1   sticky framing error
// ============================================================================
module lane_pack_8 #(
   parameter int input_x = 4,
   parameter int input_y = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_sof,
   input  logic [31:0] in_data,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_eof,
   output logic [31:0] data_out_0,
   output logic [31:0] data_out_1,
   output logic [31:0] data_out_2,
   output logic [31:0] data_out_3,
   output logic [31:0] data_out_4,
   output logic [31:0] data_out_5,
   output logic [31:0] data_out_6,
   output logic [31:0] data_out_7,
   output logic        err
);

   localparam int              N      = input_x * input_y;
   localparam int              GW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [GW-1:0]   G_LAST = GW'(N - 1);
   localparam logic [2:0]      W_LAST = 3'd7;

   logic [2:0]    wcnt;
   logic [GW-1:0] gcnt;
   // Only lanes 0..6 need staging: lane 7 is taken straight from in_data
   // on the completing cycle, which gives the single register stage latency.
   logic [31:0]   stage [0:6];
   logic [31:0]   dout  [0:7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt      <= '0;
         gcnt      <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         err       <= 1'b0;
         for (int k = 0; k < 7; k++) stage[k] <= '0;
         for (int k = 0; k < 8; k++) dout[k]  <= '0;
      end else begin
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         if (in_valid) begin
            if (in_sof) begin
               // A start-of-frame always opens a fresh group in lane 0.
               // Arriving mid-group drops the partial group; arriving on a
               // group boundary before the frame was complete is a short frame.
               stage[0] <= in_data;
               wcnt     <= 3'd1;
               gcnt     <= '0;
               if ((wcnt != 3'd0) || (gcnt != '0)) err <= 1'b1;
            end else if (wcnt == W_LAST) begin
               for (int k = 0; k < 7; k++) dout[k] <= stage[k];
               dout[7]   <= in_data;
               out_valid <= 1'b1;
               out_sof   <= (gcnt == '0);
               out_eof   <= (gcnt == G_LAST);
               gcnt      <= (gcnt == G_LAST) ? '0 : gcnt + 1'b1;
               wcnt      <= 3'd0;
            end else begin
               stage[wcnt] <= in_data;
               wcnt        <= wcnt + 3'd1;
            end
         end
      end
   end

   assign data_out_0 = dout[0];
   assign data_out_1 = dout[1];
   assign data_out_2 = dout[2];
   assign data_out_3 = dout[3];
   assign data_out_4 = dout[4];
   assign data_out_5 = dout[5];
   assign data_out_6 = dout[6];
   assign data_out_7 = dout[7];

endmodule
`default_nettype wire

// File: tb/tb_lane_pack_8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lane_pack_8
//  Purpose  : Self-checking bench for lane_pack_8. Two instances share one
//             stimulus stream: dut0 with 16 groups per frame, dut1 with one.
//             A reference model turns accepted words into expected groups;
//             a monitor pops and compares them when out_valid appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lane_pack_8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sof = 1'b0;
   logic [31:0] in_data = '0;

   logic        ov0, os0, oe0, er0;
   logic        ov1, os1, oe1, er1;
   logic [31:0] d0 [8];
   logic [31:0] d1 [8];

   always #5 clk = ~clk;

   lane_pack_8 #(.input_x(4), .input_y(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(ov0), .out_sof(os0), .out_eof(oe0),
      .data_out_0(d0[0]), .data_out_1(d0[1]), .data_out_2(d0[2]), .data_out_3(d0[3]),
      .data_out_4(d0[4]), .data_out_5(d0[5]), .data_out_6(d0[6]), .data_out_7(d0[7]),
      .err(er0));

   lane_pack_8 #(.input_x(1), .input_y(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(ov1), .out_sof(os1), .out_eof(oe1),
      .data_out_0(d1[0]), .data_out_1(d1[1]), .data_out_2(d1[2]), .data_out_3(d1[3]),
      .data_out_4(d1[4]), .data_out_5(d1[5]), .data_out_6(d1[6]), .data_out_7(d1[7]),
      .err(er1));

   typedef struct packed {
      logic [7:0][31:0] lanes;
      logic             sof;
      logic             eof;
      int               cyc;
   } exp_t;

   exp_t             q0[$];
   exp_t             q1[$];
   logic [31:0]      part[$];
   int               gidx [2];
   logic             merr [2];
   logic [7:0][31:0] last [2];
   int               nfr  [2] = '{16, 1};
   int               cyc = 0;
   int               checks = 0;
   int               failures = 0;

   logic [31:0] ftab [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int id, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s dut%0d got=%h exp=%h", name, id, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      part.delete();
      q0.delete();
      q1.delete();
      for (int id = 0; id < 2; id++) begin
         gidx[id] = 0;
         merr[id] = 1'b0;
         last[id] = '0;
      end
   endtask

   task automatic model_accept(input logic [31:0] w, input logic s);
      exp_t e;
      if (s) begin
         for (int id = 0; id < 2; id++) begin
            if (part.size() != 0 || gidx[id] != 0) merr[id] = 1'b1;
            gidx[id] = 0;
         end
         part.delete();
         part.push_back(w);
      end else begin
         part.push_back(w);
         if (part.size() == 8) begin
            for (int id = 0; id < 2; id++) begin
               for (int k = 0; k < 8; k++) e.lanes[k] = part[k];
               e.sof = (gidx[id] == 0);
               e.eof = (gidx[id] == nfr[id] - 1);
               e.cyc = cyc + 1;
               if (id == 0) q0.push_back(e); else q1.push_back(e);
               gidx[id] = (gidx[id] + 1) % nfr[id];
            end
            part.delete();
         end
      end
   endtask

   // ---------------- monitor ----------------
   task automatic mon(input int id, input logic v, input logic s, input logic e,
                      input logic [7:0][31:0] d);
      exp_t x;
      int   n;
      n = (id == 0) ? q0.size() : q1.size();
      if (v === 1'b1) begin
         if (n == 0) begin
            chk("spurious_valid", id, v, 0);
         end else begin
            x = (id == 0) ? q0.pop_front() : q1.pop_front();
            chk("lanes", id, d, x.lanes);
            chk("sof", id, s, x.sof);
            chk("eof", id, e, x.eof);
            chk("latency_cycle", id, 256'(cyc), 256'(x.cyc));
            last[id] = x.lanes;
         end
      end else begin
         chk("idle_flags", id, {s, e}, 2'b00);
         chk("hold_data", id, d, last[id]);
      end
   endtask

   always @(negedge clk) begin
      mon(0, ov0, os0, oe0, {d0[7], d0[6], d0[5], d0[4], d0[3], d0[2], d0[1], d0[0]});
      mon(1, ov1, os1, oe1, {d1[7], d1[6], d1[5], d1[4], d1[3], d1[2], d1[1], d1[0]});
   end

   // ---------------- stimulus ----------------
   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 7))
         0: return 32'h7FC00000;
         1: return 32'hFF800001;
         2: return 32'h80000000;
         3: return 32'hBF800000;
         default: return $urandom;
      endcase
   endfunction

   task automatic send(input logic [31:0] w, input logic s);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = s;
      in_data  = w;
      model_accept(w, s);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = ($urandom_range(0, 1) == 1);
         in_data  = $urandom;
      end
   endtask

   task automatic gap_send(input logic [31:0] w, input logic s);
      idle($urandom_range(0, 3));
      send(w, s);
   endtask

   task automatic chk_err();
      chk("err", 0, er0, merr[0]);
      chk("err", 1, er1, merr[1]);
   endtask

   task automatic check_reset_outputs();
      chk("rst_valid", 0, {ov0, os0, oe0, er0}, 4'b0000);
      chk("rst_valid", 1, {ov1, os1, oe1, er1}, 4'b0000);
      chk("rst_data", 0, {d0[7], d0[6], d0[5], d0[4], d0[3], d0[2], d0[1], d0[0]}, 256'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      model_reset();
      repeat (2) begin
         @(negedge clk);
         check_reset_outputs();
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      repeat (3) begin
         @(negedge clk);
         check_reset_outputs();
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      idle(2);

      // Full frame, continuous, in_sof on the first word; 1.0..8.0 lead it.
      for (int i = 0; i < 128; i++)
         send((i < 8) ? ftab[i] : rand_word(), i == 0);
      idle(3);
      chk_err();

      // Gapped groups without in_sof: framing runs from the group counter.
      for (int i = 0; i < 16; i++) gap_send(rand_word(), 1'b0);
      idle(2);
      chk_err();

      // Partial group interrupted by in_sof.
      for (int i = 0; i < 5; i++) send(rand_word(), 1'b0);
      send(rand_word(), 1'b1);
      for (int i = 0; i < 7; i++) send(rand_word(), 1'b0);
      idle(2);
      chk_err();

      // Reset in the middle of a group.
      for (int i = 0; i < 3; i++) send(rand_word(), 1'b0);
      do_reset();
      chk_err();
      for (int i = 0; i < 8; i++) send(rand_word(), 1'b0);
      idle(2);
      chk_err();

      // Random soak with occasional gaps and in_sof.
      for (int i = 0; i < 400; i++)
         gap_send(rand_word(), $urandom_range(0, 40) == 0);
      idle(3);
      chk_err();
      chk("pending_groups", 0, 256'(q0.size()), 256'd0);
      chk("pending_groups", 1, 256'(q1.size()), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
